// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encodings and widths shared by the bit-serial subtractor.
// Contents:
//   STATE_W  width of the FSM state register
//   state_t  S_IDLE=0, S_RUN=1, S_DONE=2
package serial_subtractor_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit combinational full-subtractor cell (a - b - bin).
// Ports:
//   inp_a, inp_b, inp_bin  minuend bit, subtrahend bit, borrow-in
//   out_diff               difference bit
//   out_bout               borrow-out
module full_subtractor (
    input  logic inp_a,
    input  logic inp_b,
    input  logic inp_bin,
    output logic out_diff,
    output logic out_bout
);

    assign out_diff = inp_a ^ inp_b ^ inp_bin;
    assign out_bout = (~inp_a & inp_b) | (~(inp_a ^ inp_b) & inp_bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor A - B - Bin, one bit per clock, LSB first.
// Optional feature macro: SERIAL_SUB_OVF_EN adds out_overflow (signed overflow of the result).
// Ports:
//   inp_clk, inp_rst_n   clock (rising edge), asynchronous active-low reset
//   inp_start            request, accepted when out_busy=0
//   inp_a, inp_b, inp_bin operands and borrow-in, sampled on the accept edge
//   out_busy, out_done   subtraction in progress / one-cycle result-valid pulse
//   out_diff             A-B-Bin mod 2^WIDTH, held until the next result
//   out_borrow, out_zero final borrow-out, out_diff == 0
//   out_overflow         signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             inp_clk,
    input  logic             inp_rst_n,
    input  logic             inp_start,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic             inp_bin,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             out_overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb, work, word;
    logic             br, d, bo, last, accept;

    full_subtractor u_cell (
        .inp_a   (sa[0]),
        .inp_b   (sb[0]),
        .inp_bin (br),
        .out_diff(d),
        .out_bout(bo)
    );

    assign last     = (cnt == CW'(WIDTH - 1));
    assign accept   = inp_start && (state != S_RUN);
    assign word     = {d, work[WIDTH-1:1]};
    assign out_busy = (state == S_RUN);
    assign out_done = (state == S_DONE);

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) state <= S_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = inp_start ? S_RUN : S_IDLE;
            S_RUN:   next_state = last ? S_DONE : S_RUN;
            S_DONE:  next_state = inp_start ? S_RUN : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            sa         <= '0;
            sb         <= '0;
            work       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            out_overflow <= 1'b0;
`endif
        end else if (accept) begin
            sa  <= inp_a;
            sb  <= inp_b;
            br  <= inp_bin;
            cnt <= '0;
        end else if (state == S_RUN) begin
            sa   <= sa >> 1;
            sb   <= sb >> 1;
            work <= word;
            br   <= bo;
            cnt  <= cnt + CW'(1);
            if (last) begin
                out_diff   <= word;
                out_borrow <= bo;
                out_zero   <= (word == '0);
`ifdef SERIAL_SUB_OVF_EN
                // On the last bit sa[0]/sb[0] are the original operand sign bits.
                out_overflow <= (sa[0] != sb[0]) && (d != sa[0]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed self-checking bench for serial_subtractor (WIDTH=32).
module tb_serial_subtractor;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] ia = '0, ib = '0;
    logic             ibin = 1'b0;
    logic             busy, done, borrow, zero;
    logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] prev_diff = '0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .inp_clk   (clk),
        .inp_rst_n (rst_n),
        .inp_start (start),
        .inp_a     (ia),
        .inp_b     (ib),
        .inp_bin   (ibin),
        .out_busy  (busy),
        .out_done  (done),
        .out_diff  (diff),
        .out_borrow(borrow),
        .out_zero  (zero)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .out_overflow(ovf)
`endif
    );

    task automatic check_all_zero(input string name);
        logic ov;
        ov = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ov = ovf;
`endif
        checks++;
        if ({busy, done, borrow, zero, ov} !== 5'b0 || diff !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b diff=%h borrow=%b zero=%b ovf=%b, all must be 0",
                     name, busy, done, diff, borrow, zero, ov);
        end
    endtask

    // Runs one subtraction; ign>=2 pulses a competing start while busy at that cycle.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                          input int ign, input string name);
        logic [WIDTH:0] full;
        longint         s;
        logic           exp_ovf;
        int             cycles, busy_n;
        full    = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
        s       = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        exp_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        @(negedge clk);
        start = 1'b1; ia = a; ib = b; ibin = bin;
        cycles = 0;
        busy_n = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_n++;
            if (cycles == 1) begin
                start = 1'b0; ia = $urandom; ib = $urandom; ibin = 1'($urandom);
            end
            if (ign >= 2 && cycles == ign) begin
                start = 1'b1; ia = 32'd9; ib = 32'd9; ibin = 1'b0;
            end
            if (ign >= 2 && cycles == ign + 1) start = 1'b0;
            if (cycles == 16) begin
                checks++;
                if (diff !== prev_diff) begin
                    errors++;
                    $display("FAIL %s held_diff: got %h expected %h", name, diff, prev_diff);
                end
            end
        end while (!done && cycles < WIDTH + 8);
        checks++;
        if (!done || cycles != WIDTH + 1) begin
            errors++;
            $display("FAIL %s done_timing: done=%b after %0d cycles, expected after %0d", name, done, cycles, WIDTH + 1);
        end
        checks++;
        if (busy_n != WIDTH) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, WIDTH);
        end
        checks++;
        if (diff !== full[WIDTH-1:0] || borrow !== full[WIDTH] || zero !== (full[WIDTH-1:0] == '0)) begin
            errors++;
            $display("FAIL %s result: diff=%h borrow=%b zero=%b expected diff=%h borrow=%b zero=%b",
                     name, diff, borrow, zero, full[WIDTH-1:0], full[WIDTH], full[WIDTH-1:0] == '0);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, ovf, exp_ovf);
        end
`else
        if (exp_ovf === 1'bx) $display("unreachable");
`endif
        prev_diff = full[WIDTH-1:0];
    endtask

    task automatic test_reset;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_directed;
        run_op(32'd5, 32'd3, 1'b0, 0, "5-3");
        repeat (2) @(posedge clk);
        run_op(32'd3, 32'd5, 1'b0, 0, "3-5");
        run_op(32'd0, 32'd0, 1'b1, 0, "0-0-1");
        run_op(32'h1234, 32'h1234, 1'b0, 0, "eq");
        run_op(32'h8000_0000, 32'd1, 1'b0, 0, "ovf_vec");
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b one cycle later, expected 0 0", done, busy);
        end
    endtask

    task automatic test_ignore_start;
        repeat (3) @(posedge clk);
        run_op(32'd7, 32'd2, 1'b0, 10, "ignore_start");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++)
            run_op(32'($urandom), 32'($urandom), 1'($urandom), 0, "back_to_back");
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(32'($urandom), (i % 4 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom), 1'($urandom),
                   (i % 5 == 0) ? int'($urandom_range(2, 30)) : 0, "random");
        end
    endtask

    task automatic test_abort;
        run_op(32'd3, 32'd5, 1'b0, 0, "pre_abort");
        @(negedge clk);
        start = 1'b1; ia = 32'd100; ib = 32'd1; ibin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_immediate");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all_zero("abort_held");
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: done=%b busy=%b expected 0 0", done, busy);
            end
        end
        run_op(32'd100, 32'd1, 1'b0, 0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
